// File: rtl/qam_pkg.sv
// qam_pkg: definitions shared by the 16-QAM symbol packer and the modulator.
//   SYMBOL_WIDTH - bits per 16-QAM symbol
//   qam16_sym_t  - one symbol as carried on the modulator's 4-bit input
//   IDLE_SYMBOL  - symbol inserted when no complete data symbol is queued
package qam_pkg;

  localparam int SYMBOL_WIDTH = 4;

  typedef logic [SYMBOL_WIDTH-1:0] qam16_sym_t;

  localparam qam16_sym_t IDLE_SYMBOL = 4'b0000;

endpackage

// File: rtl/symbol_fifo.sv
// symbol_fifo: small synchronous FIFO holding packed symbols.
//   clk, rst      - clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata   - write wdata when push is high and the FIFO is not full
//   pop, rdata    - rdata always shows the head entry; pop discards it
//   level         - number of occupied entries (registered pointers)
//   full, empty   - occupancy flags
module symbol_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int PTR_W  = ADDR_W + 1,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the address bits are equal.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
              (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    level   = LVL_W'(wr_ptr_q - rd_ptr_q);
    // Head is read combinationally so the owner can capture it on the same
    // edge that pops it; the owner registers it immediately.
    rdata   = mem_q[rd_ptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/qam16_symbol_packer.sv
// qam16_symbol_packer: packs a serial bit stream MSB-first into 4-bit symbols,
// queues them, and releases one symbol every SPS cycles to the modulator.
//   clk, rst             - clock, asynchronous active-high reset
//   bit_in, bit_valid    - serial data bit and its qualifier
//   bit_ready            - a bit is accepted when bit_valid && bit_ready
//   sym_out              - registered symbol, held for the full symbol period
//   sym_strobe           - one-cycle pulse when sym_out has just been updated
//   underflow            - pulses with sym_strobe when IDLE_SYMBOL was inserted
//   fifo_level           - occupied FIFO entries
module qam16_symbol_packer #(
  parameter int SYMBOL_WIDTH = qam_pkg::SYMBOL_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int SPS          = 4,
  parameter logic [SYMBOL_WIDTH-1:0] IDLE_SYMBOL = qam_pkg::IDLE_SYMBOL,
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic [SYMBOL_WIDTH-1:0] sym_out,
  output logic                    sym_strobe,
  output logic                    underflow,
  output logic [LVL_W-1:0]        fifo_level
);
  import qam_pkg::*;

  localparam int BIT_CNT_W = $clog2(SYMBOL_WIDTH);
  localparam int SYM_CNT_W = $clog2(SPS);

  // shift_q holds the bits already received for the symbol being assembled.
  logic [SYMBOL_WIDTH-2:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SYM_CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic [SYMBOL_WIDTH-1:0] sym_out_q, sym_out_d;
  logic                    sym_strobe_q, sym_strobe_d;
  logic                    underflow_q, underflow_d;

  logic                    last_bit, accept, push, pop, release_edge;
  logic [SYMBOL_WIDTH-1:0] fifo_wdata, fifo_rdata;
  logic                    fifo_full, fifo_empty;

  symbol_fifo #(
    .WIDTH (SYMBOL_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    last_bit     = (bit_cnt_q == BIT_CNT_W'(SYMBOL_WIDTH - 1));
    // Only the bit that completes a symbol needs FIFO space; earlier bits
    // just go into the shift register.
    bit_ready    = !last_bit || !fifo_full;
    accept       = bit_valid && bit_ready;
    push         = accept && last_bit;
    fifo_wdata   = {shift_q, bit_in};
    release_edge = (sym_cnt_q == SYM_CNT_W'(SPS - 1));
    // Pop decision uses the pre-edge empty flag, so a word pushed on the
    // release edge is not bypassed to the output; idle goes out instead.
    pop          = release_edge && !fifo_empty;

    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (accept) begin
      shift_d   = {shift_q[SYMBOL_WIDTH-3:0], bit_in};
      bit_cnt_d = bit_cnt_q + 1'b1;  // wraps to 0 after the last bit
    end

    sym_cnt_d    = release_edge ? '0 : sym_cnt_q + 1'b1;
    sym_out_d    = sym_out_q;
    sym_strobe_d = release_edge;
    underflow_d  = release_edge && fifo_empty;
    if (release_edge) begin
      sym_out_d = fifo_empty ? IDLE_SYMBOL : fifo_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      sym_cnt_q    <= '0;
      sym_out_q    <= IDLE_SYMBOL;
      sym_strobe_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      sym_out_q    <= sym_out_d;
      sym_strobe_q <= sym_strobe_d;
      underflow_q  <= underflow_d;
    end
  end

  assign sym_out    = sym_out_q;
  assign sym_strobe = sym_strobe_q;
  assign underflow  = underflow_q;

endmodule

// File: doc/qam16_symbol_packer.md
# qam16_symbol_packer

Upstream feeder for the 16-QAM modulator. It packs a serial bit stream into 4-bit symbols and buffers them in a small FIFO. It releases exactly one symbol every `SPS` clock cycles on a registered bus that drives the modulator's 4-bit `in` port. When no complete symbol is available, it inserts a fixed idle symbol and reports underflow.

## Interface
- `SYMBOL_WIDTH`, 4: bits per symbol; fixed for 16-QAM.
- `FIFO_DEPTH`, 4: symbol FIFO entries; power of two, ≥2.
- `SPS`, 4: clock cycles per symbol period; ≥2.
- `IDLE_SYMBOL`, 4'b0000: value emitted on underflow.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `bit_ready`  out  1  packer accepts a bit this cycle.
- `sym_out`  out  SYMBOL_WIDTH  symbol to the modulator; held for the full symbol period.
- `sym_strobe`  out  1  one-cycle pulse; `sym_out` updated this cycle.
- `underflow`  out  1  one-cycle pulse with `sym_strobe` when `IDLE_SYMBOL` was inserted.
- `fifo_level`  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries.

## Operation
- Bit accept: a bit is accepted on the rising edge where `bit_valid && bit_ready`.
- Packing: MSB-first; the first accepted bit of a symbol lands in bit 3. A 2-bit counter `bit_cnt` runs 0..3 and wraps.
- Push: on the edge accepting the bit with `bit_cnt==3`, `{shift[2:0], bit_in}` is written to the FIFO. `bit_cnt` returns to 0.
- `bit_ready` = `(bit_cnt != 3) || (fifo_level < FIFO_DEPTH)`, combinational from registered state.
  - Bits 0–2 are always accepted.
  - Bit 3 is stalled while the FIFO is full.
- Symbol timer: counter `sym_cnt` runs 0..SPS-1 and wraps. The edge where `sym_cnt==SPS-1` is the release edge.
- At the release edge:
  - FIFO non-empty: pop the head into `sym_out`; `underflow` is 0.
  - FIFO empty: `sym_out` takes `IDLE_SYMBOL`; `underflow` is 1.
  - `sym_strobe` goes to 1 for exactly the following cycle.
- `sym_out` holds its value between release edges.
- Push and pop on the same edge:
  - FIFO non-empty: both occur; `fifo_level` is unchanged.
  - FIFO empty: no bypass. Idle is emitted, underflow pulses, and the new word is stored (level 1).
- Push into a full FIFO cannot occur because `bit_ready` blocks it.
- No bit or symbol is ever dropped or reordered.

## Timing
- Reset values (asynchronous, immediate): `sym_out`=`IDLE_SYMBOL`, `sym_strobe`=0, `underflow`=0, `fifo_level`=0, `bit_cnt`=0, `sym_cnt`=0, `bit_ready`=1.
- Reset mid-operation:
  - The partial symbol is discarded and the FIFO is emptied.
  - The timer restarts, so the first release edge is the SPS-th rising edge after `rst` deasserts.
- Push latency: `fifo_level` increments in the cycle after the 4th bit is accepted.
- Bit-to-output latency: the earliest a symbol appears on `sym_out` is the next release edge after its push edge. This is 1..SPS cycles, with no same-edge bypass.
- Strobe spacing: `sym_strobe` pulses are exactly SPS cycles apart, unconditionally.
- `fifo_level` is registered and reflects pushes/pops of the previous edge.

## Structure
- Shared package `qam_pkg`: `SYMBOL_WIDTH`, `IDLE_SYMBOL`, symbol typedef `qam16_sym_t` (logic [3:0]). The modulator uses the same package.
- Sub-module `symbol_fifo`:
  - Synchronous FIFO with width/depth parameters.
  - Ports: `push`, `pop`, `wdata`, `rdata`, `level`, `full`, `empty`; same `clk`/`rst`.
  - Read/write pointers have one extra wrap bit.
- Top level holds the shift register, `bit_cnt`, `sym_cnt` and the output registers. Estimated 150–250 lines total.

## Test plan
- Reset: assert `rst` mid-run → all outputs at reset values immediately; first `sym_strobe` SPS cycles after release with `sym_out`=0000, `underflow`=1.
- Single symbol (SPS=4): bits 1,0,1,1 on consecutive cycles after reset → `fifo_level`=1 the cycle after bit 4; next strobe `sym_out`=4'b1011, `underflow`=0, then `fifo_level`=0.
- Starvation: no `bit_valid` for 40 cycles → 10 strobes, each `sym_out`=0000 with `underflow`=1, `fifo_level`=0.
- Backpressure (SPS=8): `bit_valid`=1 continuously with bits 0..63 counting pattern → `fifo_level` reaches 4; `bit_ready` drops only when `bit_cnt==3` and full. Emitted symbols equal the input nibbles in order, with no underflow after the first fill.
- Reset mid-symbol: 2 bits plus 3 FIFO entries, then `rst` → `fifo_level`=0; next 4 bits 0,1,1,0 yield `sym_out`=4'b0110 (old partial bits gone).
- Push on empty at the release edge: time the 4th bit to the release edge → that strobe shows idle with `underflow`=1 and `fifo_level`=1; the following strobe outputs the new symbol.
